aes_state_rx: RTL and testbench

Receiving end of the byte-serial AES state stream. It captures 16 en-qualified bytes, such as the add-round-key output stream, into a 128-bit state register. It optionally applies ShiftRows and presents the block as one word under a valid/ready handshake. It sits between the serial round-0 stage and the parallel round datapath.

---
 rtl/aes_state_rx.sv | 150 +++++++++++++++
 tb/tb_aes_state_rx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/aes_state_rx.sv
// Byte-serial AES state receiver: gathers 16 en-qualified bytes into a 128-bit block,
// optionally applies ShiftRows, and hands the block downstream over valid/ready.
module aes_state_rx #(
    parameter bit SHIFT_ROWS = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [7:0]   din,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         state_valid,
    output logic         busy,
    output logic         err_short,
    output logic         overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     count_q, count_d;
    logic [7:0]     cap_q [16];
    logic           cap_we;
    logic [3:0]     cap_idx;
    logic           load_out;
    logic [127:0]   out_q, out_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic           ovf_q, ovf_d;

    // Source byte for output position i = r + 4c; the 2-bit column add wraps mod 4.
    function automatic logic [3:0] src_idx(input logic [3:0] i);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] cs;
        r  = i[1:0];
        c  = i[3:2];
        cs = c + r;
        return SHIFT_ROWS ? {cs, r} : i;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = COLLECT;
            COLLECT: begin
                if (!en)                  state_d = IDLE;
                else if (count_q == 4'd15) state_d = HOLD;
            end
            HOLD:    if (out_ready) state_d = en ? COLLECT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls; every signal gets a default so no latch is inferred.
    always_comb begin
        cap_we   = 1'b0;
        cap_idx  = count_q;
        count_d  = count_q;
        load_out = 1'b0;
        valid_d  = valid_q;
        err_d    = 1'b0;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    cap_we  = 1'b1;
                    cap_idx = 4'd0;
                    count_d = 4'd1;
                end
            end
            COLLECT: begin
                if (en) begin
                    cap_we = 1'b1;
                    if (count_q == 4'd15) begin
                        load_out = 1'b1;
                        valid_d  = 1'b1;
                        count_d  = 4'd0;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end else begin
                    err_d   = 1'b1;
                    count_d = 4'd0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (en) begin
                        cap_we  = 1'b1;
                        cap_idx = 4'd0;
                        count_d = 4'd1;
                    end
                end else if (en) begin
                    ovf_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // The 16th byte is still on din when the block is loaded, so it bypasses the buffer.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] s;
            s = src_idx(4'(i));
            out_d[8*(15-i) +: 8] = (s == 4'd15) ? din : cap_q[s];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 4'd0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            if (load_out) out_q <= out_d;
        end
    end

    // NOTE: the capture buffer has no reset; its contents are never observed before being written.
    always_ff @(posedge clk) begin
        if (cap_we) cap_q[cap_idx] <= din;
    end

    assign state_out   = out_q;
    assign state_valid = valid_q;
    assign busy        = (state_q == COLLECT);
    assign err_short   = err_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_aes_state_rx.sv
// Bench for aes_state_rx: plain and ShiftRows instances share stimulus; completed blocks
// are queued as expected results and compared while state_valid is high.
module tb_aes_state_rx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [7:0]   din = 8'h00;
    logic         out_ready = 1'b0;

    logic [127:0] so0, so1;
    logic         sv0, sv1, b0, b1, e0, e1, o0, o1;

    aes_state_rx #(.SHIFT_ROWS(1'b0)) u_plain (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .out_ready(out_ready),
        .state_out(so0), .state_valid(sv0), .busy(b0), .err_short(e0), .overflow(o0)
    );

    aes_state_rx #(.SHIFT_ROWS(1'b1)) u_sr (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .out_ready(out_ready),
        .state_out(so1), .state_valid(sv1), .busy(b1), .err_short(e1), .overflow(o1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   base;
        logic [127:0] exp_plain;
        logic [127:0] exp_sr;
    } vec_t;

    vec_t         tbl [4];
    logic [127:0] q0 [$];
    logic [127:0] q1 [$];
    int           checks = 0;
    int           errors = 0;
    int           pushes = 0;
    int           xfers = 0;
    int           err_seen = 0;
    bit           mon_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [7:0] d, input logic r);
        en        = e;
        din       = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input vec_t v, input logic rdy, input bit push, input int exp_busy);
        int nb;
        nb = 0;
        if (push) begin
            q0.push_back(v.exp_plain);
            q1.push_back(v.exp_sr);
            pushes++;
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, v.base + 8'(i), rdy);
            if (b0 === 1'b1 && b1 === 1'b1) nb++;
            if (i == 0 && rdy) check("valid_drop_on_xfer", {127'b0, sv0}, 128'd0);
        end
        check("busy_cycles", 128'(nb), 128'(exp_busy));
        if (push) begin
            check("valid_after_last", {126'b0, sv0, sv1}, 128'd3);
            check("busy_low_in_hold", {126'b0, b0, b1}, 128'd0);
        end
    endtask

    // Scoreboard: whenever a block is presented it must match the oldest expected block.
    always @(negedge clk) begin
        if (mon_en) begin
            if (e0 === 1'b1) err_seen++;
            if (sv0 === 1'b1 || sv1 === 1'b1) begin
                if (q0.size() == 0) begin
                    check("unexpected_valid", {126'b0, sv0, sv1}, 128'd0);
                end else begin
                    check("out_plain", so0, q0[0]);
                    check("out_shiftrows", so1, q1[0]);
                    check("valid_pair", {126'b0, sv0, sv1}, 128'd3);
                    if (out_ready) begin
                        void'(q0.pop_front());
                        void'(q1.pop_front());
                        xfers++;
                    end
                end
            end
        end
    end

    initial begin
        int e_before;

        tbl[0] = '{8'h00, 128'h000102030405060708090A0B0C0D0E0F, 128'h00050A0F04090E03080D02070C01060B};
        tbl[1] = '{8'h10, 128'h101112131415161718191A1B1C1D1E1F, 128'h10151A1F14191E13181D12171C11161B};
        tbl[2] = '{8'hA0, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 128'hA0A5AAAFA4A9AEA3A8ADA2A7ACA1A6AB};
        tbl[3] = '{8'hF0, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, 128'hF0F5FAFFF4F9FEF3F8FDF2F7FCF1F6FB};

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h55, 1'b1);
        check("rst_out_plain", so0, 128'h0);
        check("rst_out_sr", so1, 128'h0);
        check("rst_flags", {120'b0, sv0, b0, e0, o0, sv1, b1, e1, o1}, 128'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Table blocks back to back, out_ready tied high.
        for (int k = 0; k < 4; k++) send_block(tbl[k], 1'b1, 1'b1, 15);
        drive(1'b0, 8'h00, 1'b1);
        check("b2b_valid_single", {127'b0, sv0}, 128'd0);
        check("b2b_drained", 128'(q0.size()), 128'd0);
        check("b2b_no_overflow", {126'b0, o0, o1}, 128'd0);

        // Block held while downstream stalls; the whole next block is dropped.
        e_before = err_seen;
        send_block(tbl[0], 1'b0, 1'b1, 15);
        send_block(tbl[1], 1'b0, 1'b0, 0);
        check("hold_overflow", {126'b0, o0, o1}, 128'd3);
        check("hold_valid", {127'b0, sv0}, 128'd1);
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        check("hold_valid_idle", {127'b0, sv0}, 128'd1);
        check("hold_no_err_short", 128'(err_seen - e_before), 128'd0);
        send_block(tbl[2], 1'b1, 1'b1, 15);
        drive(1'b0, 8'h00, 1'b1);
        check("hold_drained", 128'(q0.size()), 128'd0);

        // Short block aborts with a one-cycle err_short.
        e_before = err_seen;
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(i), 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check("short_err_pulse", {126'b0, e0, e1}, 128'd3);
        check("short_busy_valid", {124'b0, b0, b1, sv0, sv1}, 128'd0);
        drive(1'b0, 8'h00, 1'b1);
        check("short_err_clear", {126'b0, e0, e1}, 128'd0);
        check("short_err_count", 128'(err_seen - e_before), 128'd1);
        send_block(tbl[0], 1'b1, 1'b1, 15);
        drive(1'b0, 8'h00, 1'b1);
        check("overflow_sticky", {126'b0, o0, o1}, 128'd3);

        // Reset in the middle of a block clears everything, including overflow.
        for (int i = 0; i < 9; i++) drive(1'b1, 8'h30 + 8'(i), 1'b1);
        rst_n = 1'b0;
        drive(1'b1, 8'h39, 1'b1);
        check("midrst_out", so0 | so1, 128'h0);
        check("midrst_flags", {120'b0, sv0, b0, e0, o0, sv1, b1, e1, o1}, 128'h0);
        rst_n = 1'b1;
        e_before = err_seen;
        send_block(tbl[3], 1'b1, 1'b1, 15);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check("midrst_no_err_short", 128'(err_seen - e_before), 128'd0);
        check("final_drained", 128'(q0.size()), 128'd0);
        check("final_xfers", 128'(xfers), 128'(pushes));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
